video_timing: RTL and testbench
===============================

# video_timing

Parametrised raster timing generator for the video path. It generates the pixel clock-enable, the hSync/vSync waveforms and the active-area flag, plus framebuffer read coordinates issued a fixed number of pixels ahead of the beam so the memory manager can prefetch. It also provides optional line-start/frame-start strobes and a programmable raster-line interrupt. It sits between the clock generator and the video output / memory manager, and replaces their hard-wired 640x480 counters.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths, in pixels
- V_ACTIVE, 480, visible lines
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths, in lines
- H_SYNC_POL / V_SYNC_POL, 0 / 0, asserted sync level (0 = active-low)
- CLOCK_DIV, 2, clocks per pixel (≥1)
- SCALE, 2, screen pixels per framebuffer pixel, both axes (≥1)
- FETCH_LEAD, 2, pixels by which the coordinates lead the beam (0 ≤ FETCH_LEAD < H_ACTIVE)
- X_WIDTH / Y_WIDTH, 9 / 8, coordinate widths; must hold H_ACTIVE/SCALE−1 and V_ACTIVE/SCALE−1
- Clock and reset: one clock; reset is asynchronous and active-high.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- pixelTick  out  1  one-clock pulse every CLOCK_DIV clocks
- hSync  out  1  horizontal sync at H_SYNC_POL
- vSync  out  1  vertical sync at V_SYNC_POL
- active  out  1  beam is in the visible area
- xCoord  out  X_WIDTH  framebuffer column of the beam pixel + FETCH_LEAD
- yCoord  out  Y_WIDTH  framebuffer row of that same lead pixel
- lineStart  out  1  pulse when hCount becomes 0
- frameStart  out  1  pulse when hCount and vCount both become 0
- rasterLine  in  Y_WIDTH  interrupt compare row, in framebuffer rows
- irqAck  in  1  one-clock pulse that clears rasterIrq
- rasterIrq  out  1  sticky raster interrupt

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK.
  - V_TOTAL is defined the same way from the vertical parameters.
- Phase counter: counts 0..CLOCK_DIV−1. pixelTick is high while phase = CLOCK_DIV−1. With CLOCK_DIV = 1, pixelTick is always high.
- Horizontal counter: on pixelTick, hCount increments and wraps at H_TOTAL−1.
- Vertical counter: on the hCount wrap, vCount increments and wraps at V_TOTAL−1.
- Output decode, using the new counter values:
  - hSync is asserted for hCount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vSync uses the same rule on vCount with the vertical parameters.
  - active = (hCount < H_ACTIVE) && (vCount < V_ACTIVE).
- Lead pixel:
  - L = hCount + FETCH_LEAD. If L ≥ H_TOTAL, subtract H_TOTAL and use row vCount+1, wrapping at V_TOTAL.
  - When L < H_ACTIVE and that row < V_ACTIVE: xCoord = L/SCALE and yCoord = row/SCALE (integer divide).
  - Otherwise both coordinates hold their last value.
- Raster interrupt:
  - rasterIrq sets on the pixelTick where hCount becomes H_ACTIVE and vCount = rasterLine·SCALE + SCALE−1, i.e. the start of hblank after the last scanline of that row.
  - It clears on irqAck. If a set and an ack occur in the same clock, set wins.
  - A rasterLine ≥ V_ACTIVE/SCALE never fires.
- Reset values:
  - Counters and phase: 0.
  - hSync and vSync: inactive level.
  - active, pixelTick, lineStart, frameStart, rasterIrq: 0.
  - xCoord, yCoord: 0.
- Reset asserted mid-frame: all of the above return to reset values immediately. Counting restarts from hCount = vCount = 0. The first pixelTick arrives CLOCK_DIV clocks after reset is released.

## Timing
- Every output is registered and updates on the same edge as the counters. There are no combinational paths from inputs to outputs.
- pixelTick is asserted for one clock per pixel. lineStart and frameStart are one-clock pulses aligned with the counter update.
- Outputs other than pixelTick change only on pixelTick edges. The exception is rasterIrq clearing on irqAck, which takes effect on the next edge.
- At the defaults:
  - Line = 1600 clocks; frame = 840,000 clocks.
  - hSync low for 192 clocks; vSync low for 3200 clocks.

## Configuration
- VIDEO_TIMING_RASTER_IRQ_EN defined: the compare and sticky-flag logic is built as described above.
- Not defined: rasterIrq is tied to 0, rasterLine and irqAck are ignored, and the ports remain present.

## Structure
- Package video_pkg holds:
  - the default timing localparams and a timing_t struct (active/front/sync/back);
  - the H_TOTAL and V_TOTAL derivation functions;
  - a clog2-based coordinate-width helper.
- Sub-module pixel_tick_gen (phase counter → pixelTick). It is parametrised by CLOCK_DIV and shares clock and reset.

## Test plan
- Reset release at defaults → first pixelTick 2 clocks later. hSync first falls when hCount becomes 656, 1312 clocks after release. It stays low 192 clocks and repeats every 1600 clocks.
- Run to line 490 → vSync low for exactly 3200 clocks. frameStart pulses once per 840,000 clocks, coincident with lineStart.
- FETCH_LEAD = 2, SCALE = 2:
  - hCount = 0, vCount = 10 → xCoord = 1, yCoord = 5.
  - hCount = 798, vCount = 10 → xCoord = 0, yCoord = 5 (lead pixel is 0 of line 11).
  - hCount = 700 → xCoord holds 319.
- rasterLine = 100, macro defined → rasterIrq rises when hCount becomes 640 on vCount 201. It stays high until irqAck. An irqAck coinciding with the next set leaves it at 1.
- Reset asserted mid-line (hCount ≈ 400, vCount ≈ 300) → outputs at reset values within the same clock. Timing restarts from 0,0 after release.
- CLOCK_DIV = 1, SCALE = 1, H_SYNC_POL = 1 → pixelTick constant high, xCoord = hCount + FETCH_LEAD, hSync high for 96 clocks.

Source files
------------

// File: rtl/video_pkg.sv
// Shared timing types, default 640x480 raster parameters and width helpers for video_timing.
package video_pkg;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLOCK_DIV = 2;
    localparam int DEF_SCALE     = 2;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } timing_t;

    function automatic int span_total(input timing_t t);
        return int'(t.active) + int'(t.front) + int'(t.sync) + int'(t.back);
    endfunction

    function automatic int h_total(input timing_t t);
        return span_total(t);
    endfunction

    function automatic int v_total(input timing_t t);
        return span_total(t);
    endfunction

    // Bits needed to hold 0 .. extent/scale-1.
    function automatic int coord_width(input int extent, input int scale);
        int n;
        n = extent / scale;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Phase counter dividing the system clock down to the pixel rate.
// advance is the combinational "next edge is a pixel edge" term; pixelTick is its registered copy.
module pixel_tick_gen #(
    parameter int CLOCK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    output logic advance,
    output logic pixelTick
);
    localparam int PW = (CLOCK_DIV <= 1) ? 1 : $clog2(CLOCK_DIV);

    logic [PW-1:0] phase_q, phase_d;
    logic          tick_q;

    assign advance   = (phase_q == PW'(CLOCK_DIV - 1));
    assign pixelTick = tick_q;

    always_comb begin
        phase_d = advance ? '0 : phase_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tick_q  <= advance;
        end
    end
endmodule

// File: rtl/video_timing.sv
// Raster timing generator: syncs, active flag, lead-pixel prefetch coordinates and line/frame strobes.
// Define VIDEO_TIMING_RASTER_IRQ_EN to build the raster-line interrupt; otherwise rasterIrq is tied low.
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CLOCK_DIV  = DEF_CLOCK_DIV,
    parameter int SCALE      = DEF_SCALE,
    parameter int FETCH_LEAD = 2,
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 8
) (
    input  logic               clock,
    input  logic               reset,
    output logic               pixelTick,
    output logic               hSync,
    output logic               vSync,
    output logic               active,
    output logic [X_WIDTH-1:0] xCoord,
    output logic [Y_WIDTH-1:0] yCoord,
    output logic               lineStart,
    output logic               frameStart,
    input  logic [Y_WIDTH-1:0] rasterLine,
    input  logic               irqAck,
    output logic               rasterIrq
);
    localparam timing_t H_CFG = '{active: 16'(H_ACTIVE), front: 16'(H_FRONT),
                                  sync: 16'(H_SYNC), back: 16'(H_BACK)};
    localparam timing_t V_CFG = '{active: 16'(V_ACTIVE), front: 16'(V_FRONT),
                                  sync: 16'(V_SYNC), back: 16'(V_BACK)};
    localparam int H_TOTAL  = h_total(H_CFG);
    localparam int V_TOTAL  = v_total(V_CFG);
    localparam int HW       = coord_width(H_TOTAL, 1);
    localparam int VW       = coord_width(V_TOTAL, 1);
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    logic               adv;
    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    int                 hn, vn, lead, row;
    logic               lead_ok;
    logic               hsync_q, vsync_q, active_q, line_q, frame_q;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;

    pixel_tick_gen #(.CLOCK_DIV(CLOCK_DIV)) u_tick (
        .clock    (clock),
        .reset    (reset),
        .advance  (adv),
        .pixelTick(pixelTick)
    );

    // Everything below decodes the post-edge counter values so outputs line up with the counters.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (adv) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        hn   = int'(h_d);
        vn   = int'(v_d);
        lead = hn + FETCH_LEAD;
        row  = vn;
        if (lead >= H_TOTAL) begin
            lead = lead - H_TOTAL;
            row  = (vn == V_TOTAL - 1) ? 0 : vn + 1;
        end
        lead_ok = (lead < H_ACTIVE) && (row < V_ACTIVE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= ~H_SYNC_POL;
            vsync_q  <= ~V_SYNC_POL;
            active_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            line_q  <= adv && (hn == 0);
            frame_q <= adv && (hn == 0) && (vn == 0);
            if (adv) begin
                hsync_q  <= (hn >= HS_START && hn < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
                vsync_q  <= (vn >= VS_START && vn < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
                active_q <= (hn < H_ACTIVE) && (vn < V_ACTIVE);
                if (lead_ok) begin
                    x_q <= X_WIDTH'(lead / SCALE);
                    y_q <= Y_WIDTH'(row / SCALE);
                end
            end
        end
    end

    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign active     = active_q;
    assign lineStart  = line_q;
    assign frameStart = frame_q;
    assign xCoord     = x_q;
    assign yCoord     = y_q;

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    localparam int IRQ_ROWS = V_ACTIVE / SCALE;

    logic irq_q, irq_set;

    // Fires at the start of hblank after the last scanline of the compare row.
    always_comb begin
        irq_set = adv && (hn == H_ACTIVE) && (int'(rasterLine) < IRQ_ROWS)
                  && (vn == int'(rasterLine) * SCALE + SCALE - 1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irqAck) begin
            irq_q <= 1'b0;
        end
    end

    assign rasterIrq = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{rasterLine, irqAck};
    assign rasterIrq         = 1'b0;
`endif
endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: three instances (defaults, a tiny raster, CLOCK_DIV=1) against a pixel-index model.
module tb_video_timing;

    typedef struct packed {
        logic        pt, hs, vs, act, ls, fs, irq;
        logic [15:0] x, y;
    } obs_t;

    typedef struct {
        int cd, ha, hf, hs, hb, va, vf, vs, vb, sc, fl;
        bit hp, vp;
    } cfg_t;

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] rl_b;
    logic       ack_b;
    int         kclk;
    int         checks;
    int         errors;
    cfg_t       ca, cb, cc;

    logic       pt_a, hs_a, vs_a, act_a, ls_a, fs_a, irq_a;
    logic [8:0] x_a;
    logic [7:0] y_a;
    logic       pt_b, hs_b, vs_b, act_b, ls_b, fs_b, irq_b;
    logic [3:0] x_b;
    logic [2:0] y_b;
    logic       pt_c, hs_c, vs_c, act_c, ls_c, fs_c, irq_c;
    logic [9:0] x_c;
    logic [8:0] y_c;

    video_timing u_a (
        .clock(clk), .reset(rst), .pixelTick(pt_a), .hSync(hs_a), .vSync(vs_a),
        .active(act_a), .xCoord(x_a), .yCoord(y_a), .lineStart(ls_a), .frameStart(fs_a),
        .rasterLine(8'd250), .irqAck(1'b0), .rasterIrq(irq_a)
    );

    video_timing #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .CLOCK_DIV(3), .SCALE(2),
        .FETCH_LEAD(3), .X_WIDTH(4), .Y_WIDTH(3)
    ) u_b (
        .clock(clk), .reset(rst), .pixelTick(pt_b), .hSync(hs_b), .vSync(vs_b),
        .active(act_b), .xCoord(x_b), .yCoord(y_b), .lineStart(ls_b), .frameStart(fs_b),
        .rasterLine(rl_b), .irqAck(ack_b), .rasterIrq(irq_b)
    );

    video_timing #(
        .CLOCK_DIV(1), .SCALE(1), .H_SYNC_POL(1'b1), .X_WIDTH(10), .Y_WIDTH(9)
    ) u_c (
        .clock(clk), .reset(rst), .pixelTick(pt_c), .hSync(hs_c), .vSync(vs_c),
        .active(act_c), .xCoord(x_c), .yCoord(y_c), .lineStart(ls_c), .frameStart(fs_c),
        .rasterLine(9'd500), .irqAck(1'b0), .rasterIrq(irq_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release; equals k at the #1 sample after edge k.
    always @(posedge clk or posedge rst) begin
        if (rst) kclk <= 0;
        else     kclk <= kclk + 1;
    end

    // Expected outputs after edge k: t pixels have elapsed, the beam sits at absolute pixel t.
    function automatic obs_t model(input cfg_t c, input int k, input logic irq);
        obs_t e;
        int   ht, vt, t, h, v, p, lh, lr, lo;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        t  = k / c.cd;
        h  = t % ht;
        v  = (t / ht) % vt;
        e  = '0;
        e.pt  = (k > 0) && (k % c.cd == 0);
        e.hs  = !c.hp;
        e.vs  = !c.vp;
        e.irq = irq;
        if (t > 0) begin
            e.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
            e.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : !c.vp;
            e.act = (h < c.ha) && (v < c.va);
            e.ls  = e.pt && (h == 0);
            e.fs  = e.ls && (v == 0);
            lo    = (t > ht * vt) ? t - ht * vt : 1;
            for (int j = t; j >= lo; j--) begin
                p  = j + c.fl;
                lh = p % ht;
                lr = (p / ht) % vt;
                if (lh < c.ha && lr < c.va) begin
                    e.x = 16'(lh / c.sc);
                    e.y = 16'(lr / c.sc);
                    break;
                end
            end
        end
        return e;
    endfunction

    function automatic obs_t obs_of(input int which);
        obs_t o;
        o = '0;
        case (which)
            0: begin
                o.pt = pt_a; o.hs = hs_a; o.vs = vs_a; o.act = act_a; o.ls = ls_a;
                o.fs = fs_a; o.irq = irq_a; o.x = 16'(x_a); o.y = 16'(y_a);
            end
            1: begin
                o.pt = pt_b; o.hs = hs_b; o.vs = vs_b; o.act = act_b; o.ls = ls_b;
                o.fs = fs_b; o.irq = irq_b; o.x = 16'(x_b); o.y = 16'(y_b);
            end
            default: begin
                o.pt = pt_c; o.hs = hs_c; o.vs = vs_c; o.act = act_c; o.ls = ls_c;
                o.fs = fs_c; o.irq = irq_c; o.x = 16'(x_c); o.y = 16'(y_c);
            end
        endcase
        return o;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        ack_b = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            o = obs_of(w);
            e = model((w == 0) ? ca : (w == 1) ? cb : cc, 0, 1'b0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_values inst=%0d got %h want %h", w, o, e);
            end
        end
    endtask

    task automatic test_default_timing();
        obs_t o, e;
        int   lerr, first_tick, nfall, fall0, fall1, rise0;
        logic prev_hs;
        lerr = 0; first_tick = -1; nfall = 0; fall0 = -1; fall1 = -1; rise0 = -1;
        prev_hs = 1'b1;
        do_reset();
        for (int n = 0; n < 3400; n++) begin
            @(posedge clk);
            #1;
            o = obs_of(0);
            e = model(ca, kclk, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL default_cycle k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
            if (first_tick < 0 && o.pt) first_tick = kclk;
            if (prev_hs && !o.hs) begin
                if (nfall == 0) fall0 = kclk;
                else if (nfall == 1) fall1 = kclk;
                nfall++;
            end
            if (!prev_hs && o.hs && rise0 < 0) rise0 = kclk;
            prev_hs = o.hs;
        end
        checks++;
        if (first_tick !== 2) begin
            errors++; $display("FAIL first_tick got %0d want 2", first_tick);
        end
        checks++;
        if (fall0 !== 1312) begin
            errors++; $display("FAIL hsync_first_fall got %0d want 1312", fall0);
        end
        checks++;
        if (rise0 - fall0 !== 192) begin
            errors++; $display("FAIL hsync_low_len got %0d want 192", rise0 - fall0);
        end
        checks++;
        if (fall1 - fall0 !== 1600) begin
            errors++; $display("FAIL hsync_period got %0d want 1600", fall1 - fall0);
        end
    endtask

    // Continues the same run into line 10/11 to hit the lead-pixel wrap cases.
    task automatic test_default_lead();
        obs_t o, e;
        int   lerr;
        lerr = 0;
        for (int n = 0; n < 20000 && kclk < 17610; n++) begin
            @(posedge clk);
            #1;
            o = obs_of(0);
            e = model(ca, kclk, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL lead_cycle k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
            if (kclk == 16000) begin
                checks++;
                if (x_a !== 9'd1 || y_a !== 8'd5) begin
                    errors++; $display("FAIL lead_h0_v10 got x=%0d y=%0d want x=1 y=5", x_a, y_a);
                end
            end
            if (kclk == 17400) begin
                checks++;
                if (x_a !== 9'd319 || y_a !== 8'd5) begin
                    errors++; $display("FAIL lead_hold_h700 got x=%0d y=%0d want x=319 y=5", x_a, y_a);
                end
            end
            if (kclk == 17596) begin
                checks++;
                if (x_a !== 9'd0 || y_a !== 8'd5) begin
                    errors++; $display("FAIL lead_wrap_h798 got x=%0d y=%0d want x=0 y=5", x_a, y_a);
                end
            end
        end
    endtask

    // Tiny raster with an out-of-range compare row: full frames, vSync width, frame strobes.
    task automatic test_small_frame();
        obs_t o, e;
        int   lerr, vs_len, fs0, fs1, fs_no_ls;
        lerr = 0; vs_len = 0; fs0 = -1; fs1 = -1; fs_no_ls = 0;
        rl_b = 3'($urandom_range(6, 7));
        do_reset();
        for (int n = 0; n < 2 * 1224 + 50; n++) begin
            @(posedge clk);
            #1;
            o = obs_of(1);
            e = model(cb, kclk, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL small_cycle k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
            if (kclk <= 1224 && o.vs) vs_len++;
            if (o.fs && !o.ls) fs_no_ls++;
            if (o.fs) begin
                if (fs0 < 0) fs0 = kclk;
                else if (fs1 < 0) fs1 = kclk;
            end
            ack_b = ($urandom_range(0, 19) == 0);
        end
        ack_b = 1'b0;
        checks++;
        if (vs_len !== 144) begin
            errors++; $display("FAIL vsync_len got %0d want 144", vs_len);
        end
        checks++;
        if (fs0 !== 1224 || fs1 - fs0 !== 1224) begin
            errors++; $display("FAIL frame_start got %0d,%0d want 1224,2448", fs0, fs1);
        end
        checks++;
        if (fs_no_ls !== 0) begin
            errors++; $display("FAIL frame_without_line got %0d want 0", fs_no_ls);
        end
    endtask

    task automatic test_raster_irq();
        obs_t o, e;
        int   lerr, nsets, first_rise, t, nk, nt, target, want_rise;
        logic exp_irq, set, set_next, coinc, prev_irq;
        lerr = 0; nsets = 0; first_rise = -1; exp_irq = 1'b0; coinc = 1'b0; prev_irq = 1'b0;
        rl_b   = 3'($urandom_range(0, 5));
        target = int'(rl_b) * 2 + 1;
        do_reset();
        for (int n = 0; n < 3 * 1224 + 20; n++) begin
            @(posedge clk);
            #1;
            t       = kclk / 3;
            set     = IRQ_EN && (kclk % 3 == 0) && (t % 24 == 16) && ((t / 24) % 17 == target);
            exp_irq = set ? 1'b1 : (ack_b ? 1'b0 : exp_irq);
            o = obs_of(1);
            e = model(cb, kclk, exp_irq);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL irq_cycle k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
            if (coinc) begin
                checks++;
                if (o.irq !== IRQ_EN) begin
                    errors++; $display("FAIL irq_ack_collide got %0d want %0d", o.irq, IRQ_EN);
                end
                coinc = 1'b0;
            end
            if (o.irq && !prev_irq && first_rise < 0) first_rise = kclk;
            prev_irq = o.irq;
            if (set) nsets++;
            nk       = kclk + 1;
            nt       = nk / 3;
            set_next = (nk % 3 == 0) && (nt % 24 == 16) && ((nt / 24) % 17 == target);
            if (nsets == 1) begin
                ack_b = set_next;
                coinc = set_next;
            end else begin
                ack_b = ($urandom_range(0, 29) == 0);
            end
        end
        ack_b     = 1'b0;
        want_rise = IRQ_EN ? (target * 24 + 16) * 3 : -1;
        checks++;
        if (first_rise !== want_rise) begin
            errors++; $display("FAIL irq_first_rise row=%0d got %0d want %0d", rl_b, first_rise, want_rise);
        end
    endtask

    task automatic test_midframe_reset();
        obs_t o, e;
        int   lerr, first_tick;
        lerr = 0; first_tick = -1;
        rl_b = 3'd7;
        do_reset();
        repeat ($urandom_range(300, 1100)) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int w = 0; w < 2; w++) begin
            o = obs_of(w);
            e = model((w == 0) ? ca : cb, 0, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL async_reset inst=%0d got %h want %h", w, o, e);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 250; n++) begin
            @(posedge clk);
            #1;
            o = obs_of(1);
            e = model(cb, kclk, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL restart_b k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
            if (first_tick < 0 && o.pt) first_tick = kclk;
            o = obs_of(0);
            e = model(ca, kclk, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL restart_a k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
        end
        checks++;
        if (first_tick !== 3) begin
            errors++; $display("FAIL restart_first_tick got %0d want 3", first_tick);
        end
    endtask

    task automatic test_clockdiv1();
        obs_t o, e;
        int   lerr, n_low, n_hs;
        lerr = 0; n_low = 0; n_hs = 0;
        do_reset();
        for (int n = 0; n < 900; n++) begin
            @(posedge clk);
            #1;
            o = obs_of(2);
            e = model(cc, kclk, 1'b0);
            checks++;
            if (o !== e) begin
                errors++; lerr++;
                $display("FAIL div1_cycle k=%0d got %h want %h", kclk, o, e);
                if (lerr >= 10) break;
            end
            if (!o.pt) n_low++;
            if (o.hs) n_hs++;
            if (kclk == 100) begin
                checks++;
                if (x_c !== 10'd102) begin
                    errors++; $display("FAIL div1_x_lead got %0d want 102", x_c);
                end
            end
        end
        checks++;
        if (n_low !== 0) begin
            errors++; $display("FAIL div1_tick_low got %0d want 0", n_low);
        end
        checks++;
        if (n_hs !== 96) begin
            errors++; $display("FAIL div1_hsync_high got %0d want 96", n_hs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        rl_b   = 3'd7;
        ack_b  = 1'b0;
        ca = '{cd: 2, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
               sc: 2, fl: 2, hp: 1'b0, vp: 1'b0};
        cb = '{cd: 3, ha: 16, hf: 2, hs: 3, hb: 3, va: 12, vf: 1, vs: 2, vb: 2,
               sc: 2, fl: 3, hp: 1'b0, vp: 1'b1};
        cc = '{cd: 1, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33,
               sc: 1, fl: 2, hp: 1'b1, vp: 1'b0};
        #1 rst = 1'b1;
        test_reset();
        test_default_timing();
        test_default_lead();
        test_small_frame();
        test_raster_irq();
        test_midframe_reset();
        test_clockdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
